div_iter: RTL
=============

// Module: div_iter
// PURPOSE
// Iterative restoring divider: the responder side of the start/busy handshake
// driven by the single-cycle control unit for div/divu. It accepts a one-cycle
// start, holds busy high while computing (the control unit stalls the PC on
// busy), then returns quotient and remainder for the LO/HI registers. It is
// instantiated once unsigned (divu) and once signed (div).
// PARAMETERS
// WIDTH   32  operand/result width in bits (>=4)
// SIGNED  0   0: unsigned (divu); 1: two's-complement (div)
// PORTS
// clk       in   1      rising-edge clock
// reset     in   1      synchronous, active-high reset
// start     in   1      request; sampled only while busy=0
// dividend  in   WIDTH  rs operand, captured when start is accepted
// divisor   in   WIDTH  rt operand, captured when start is accepted
// q         out  WIDTH  quotient (to LO), registered, held until next accept
// r         out  WIDTH  remainder (to HI), registered, held until next accept
// busy      out  1      high while an operation is in progress
// done      out  1      one-cycle pulse: q/r just updated
// BEHAVIOUR
// - Reset (sync, active-high): state=IDLE; q=0, r=0, busy=0, done=0, count=0.
//   Reset mid-operation aborts it; no done pulse; operands discarded.
// - FSM: IDLE -> RUN -> FIX -> IDLE.
//   IDLE: if start at edge E0, capture operands (SIGNED=1: capture magnitudes and
//     both sign bits), load count=WIDTH, busy<=1, go to RUN. Otherwise hold.
//   RUN: one quotient bit per edge, MSB first (shift {rem,quo} left 1; trial
//     subtract divisor magnitude; keep if non-negative, set quo LSB=1). count
//     decrements. After WIDTH iterations (edges E1..E_WIDTH), go to FIX.
//   FIX (edge E_WIDTH+1): apply sign, load q/r, busy<=0, done<=1, go to IDLE.
// - Latency: busy is high for exactly WIDTH+1 cycles (33 at WIDTH=32). done is
//   high in the first cycle after busy falls, for one cycle.
// - done and start may coincide: the new start is accepted (busy=0 that cycle).
// - start while busy=1: ignored; the current operation is unaffected.
// - Sign rules (SIGNED=1): quotient negated iff the operand signs differ.
//   Remainder takes the dividend's sign. Magnitudes use WIDTH-bit unsigned math,
//   so -2^(W-1)/-1 gives q=0x80000000 and r=0 (no trap, no flag).
// - Divide by zero (either mode): q=all ones, r=dividend exactly as captured.
//   Timing is the same (WIDTH+1 busy cycles).
// - q/r change only on the FIX edge or on reset; they are stable whenever busy=1.
// TESTING
// 1 U: 100/7, start for 1 cycle -> busy=1 for 33 cycles; then q=14, r=2,
//   done=1 for 1 cycle.
// 2 S: 0xFFFFFFF9(-7)/2 -> q=0xFFFFFFFD(-3), r=0xFFFFFFFF(-1); 7/-2 -> q=-3, r=1.
// 3 Either mode: 0x1234/0 -> q=0xFFFFFFFF, r=0x1234; S: 0x80000000/0xFFFFFFFF
//   -> q=0x80000000, r=0.
// 4 U: 50/5 started; start=1 with operands 9/3 at busy cycle 10 -> ignored;
//   result q=10, r=0 after 33 cycles.
// 5 U: back-to-back: start held high -> second op accepted in the done cycle;
//   q/r stable while busy; the second result arrives 34 cycles after the first.
// 6 U: reset at busy cycle 20 -> next cycle busy=0, q=0, r=0, no done pulse;
//   a following 100/7 completes normally (q=14, r=2).

Source files
------------

// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative restoring divider with start/busy/done handshake
// Produces quotient and remainder in WIDTH+1 busy cycles; SIGNED selects div vs divu.
module div_iter #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH:0]   shifted, trial;

    always_comb begin
        dvd_neg = SIGNED && dividend[WIDTH-1];
        dvs_neg = SIGNED && divisor[WIDTH-1];
        dvd_mag = dvd_neg ? (~dividend + ONE) : dividend;
        dvs_mag = dvs_neg ? (~divisor + ONE) : divisor;
        // Partial remainder always stays below the divisor, so WIDTH+1 bits hold the shift.
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};

        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        dvd_d   = dvd_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zero_d  = zero_q;
        q_d     = q_q;
        r_d     = r_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d   = '0;
                    quo_d   = dvd_mag;
                    dvs_d   = dvs_mag;
                    dvd_d   = dividend;
                    qneg_d  = dvd_neg ^ dvs_neg;
                    rneg_d  = dvd_neg;
                    zero_d  = (divisor == '0);
                    count_d = CW'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                quo_d   = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                rem_d   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (zero_q) begin
                    q_d = '1;
                    r_d = dvd_q;
                end else begin
                    q_d = qneg_q ? (~quo_q + ONE) : quo_q;
                    r_d = rneg_q ? (~rem_q + ONE) : rem_q;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            dvd_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            dvd_q   <= dvd_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zero_q  <= zero_d;
            q_q     <= q_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q    = q_q;
    assign r    = r_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
